// File: rtl/sr_imem_loader_pkg.sv
// Shared types and constants for the schoolRISCV instruction memory and its byte-stream loader.
package sr_imem_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      LEN0 = 2'd1,
      LEN1 = 2'd2,
      DATA = 2'd3
   } imem_state_t;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;
   localparam int          LEN_W    = 16;

endpackage

// File: rtl/sr_imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler: first accepted byte lands in [7:0].
// word_valid_o pulses combinationally with the 4th accepted byte; clear drops any partial word.
module sr_byte_to_word (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  byte_i,
   input  logic        accept_i,
   input  logic        clear_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] hold_q, hold_d;

   always_comb begin
      cnt_d  = cnt_q;
      hold_d = hold_q;
      if (clear_i) begin
         cnt_d = 2'd0;
      end else if (accept_i) begin
         cnt_d  = cnt_q + 2'd1;
         hold_d = {byte_i, hold_q[23:8]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= 2'd0;
         hold_q <= 24'd0;
      end else begin
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
      end
   end

   // The 4th byte bypasses the holding register so the word is written on its accept edge.
   assign word_o       = {byte_i, hold_q};
   assign word_valid_o = accept_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/sr_imem_loader.sv
// Instruction memory with combinational fetch plus a length-prefixed byte-stream loader
// that holds the core in reset while the memory is being filled.
module sr_imem_loader #(
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] NOP_WORD = sr_imem_pkg::NOP_WORD
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_data_o,
   input  logic        in_valid_i,
   input  logic [7:0]  in_data_i,
   output logic        in_ready_o,
   input  logic        load_start_i,
   output logic        cpu_rst_o,
   output logic        loading_o,
   output logic        load_done_o,
   output logic        overflow_o
);
   import sr_imem_pkg::*;

   localparam int unsigned DEPTH = 1 << ADDR_W;

   imem_state_t      state_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] wptr_q;
   logic             cpu_rst_q;
   logic             load_done_q;
   logic             overflow_q;
   logic [31:0]      mem_q [DEPTH];

   logic             accept;
   logic             word_vld;
   logic [31:0]      word;
   logic             in_mem;
   logic             last_word;
   logic [LEN_W-1:0] len_full;

   assign accept    = in_valid_i && (state_q != RUN);
   assign in_mem    = 32'(wptr_q) < DEPTH;
   assign last_word = (wptr_q == len_q - LEN_W'(1));
   assign len_full  = {in_data_i, len_q[7:0]};

   sr_byte_to_word u_b2w (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_i       (in_data_i),
      .accept_i     (accept && (state_q == DATA)),
      .clear_i      (state_q == RUN),
      .word_o       (word),
      .word_valid_o (word_vld)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         cpu_rst_q   <= 1'b1;
         load_done_q <= 1'b0;
         overflow_q  <= 1'b0;
         len_q       <= '0;
         wptr_q      <= '0;
      end else begin
         load_done_q <= 1'b0;
         case (state_q)
            RUN: begin
               cpu_rst_q <= load_start_i;
               if (load_start_i) begin
                  state_q    <= LEN0;
                  overflow_q <= 1'b0;
                  wptr_q     <= '0;
               end
            end
            LEN0: if (accept) begin
               len_q[7:0] <= in_data_i;
               state_q    <= LEN1;
            end
            LEN1: if (accept) begin
               len_q <= len_full;
               if (len_full == '0) begin
                  state_q     <= RUN;
                  cpu_rst_q   <= 1'b0;
                  load_done_q <= 1'b1;
               end else begin
                  state_q <= DATA;
               end
            end
            DATA: if (word_vld) begin
               wptr_q <= wptr_q + LEN_W'(1);
               if (!in_mem) overflow_q <= 1'b1;
               // Core is released on the same edge as the last write.
               if (last_word) begin
                  state_q     <= RUN;
                  cpu_rst_q   <= 1'b0;
                  load_done_q <= 1'b1;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && word_vld && in_mem) mem_q[wptr_q[ADDR_W-1:0]] <= word;
   end

   assign instr_data_o = ((instr_addr_i >> ADDR_W) == 32'd0) ? mem_q[instr_addr_i[ADDR_W-1:0]]
                                                             : NOP_WORD;
   assign in_ready_o   = (state_q != RUN);
   assign loading_o    = (state_q != RUN);
   assign cpu_rst_o    = cpu_rst_q;
   assign load_done_o  = load_done_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_sr_imem_loader.sv
// Bench for sr_imem_loader: a 64-word and a 4-word instance share one byte stream and are
// compared against a frame-level memory model.
module tb_sr_imem_loader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, load_start;
   logic [7:0]  in_data;
   logic [31:0] instr_addr;
   logic [31:0] data_a, data_b;
   logic        rdy_a, rdy_b, crst_a, crst_b, ld_a, ld_b, done_a, done_b, ovf_a, ovf_b;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_a [64];
   bit          known_a [64];
   logic [31:0] exp_b [4];
   bit          known_b [4];
   bit          ovf_exp_a, ovf_exp_b;

   sr_imem_loader #(.ADDR_W(6)) dut_a (
      .clk_i(clk), .rst_i(rst), .instr_addr_i(instr_addr), .instr_data_o(data_a),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy_a),
      .load_start_i(load_start), .cpu_rst_o(crst_a), .loading_o(ld_a),
      .load_done_o(done_a), .overflow_o(ovf_a)
   );

   sr_imem_loader #(.ADDR_W(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .instr_addr_i(instr_addr), .instr_data_o(data_b),
      .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy_b),
      .load_start_i(load_start), .cpu_rst_o(crst_b), .loading_o(ld_b),
      .load_done_o(done_b), .overflow_o(ovf_b)
   );

   typedef struct {
      logic rst, ls, vld;
      logic e_crst, e_rdy, e_ld;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Frame-level model: only words whose four data bytes were all accepted land in memory.
   task automatic model_frame(input logic [7:0] b[$], input int nacc);
      int n;
      logic [31:0] w32;
      n = int'({b[1], b[0]});
      ovf_exp_a = 1'b0;
      ovf_exp_b = 1'b0;
      for (int w = 0; w < n; w++) begin
         if (2 + 4*w + 4 > nacc) break;
         w32 = {b[2+4*w+3], b[2+4*w+2], b[2+4*w+1], b[2+4*w]};
         if (w < 64) begin exp_a[w] = w32; known_a[w] = 1'b1; end else ovf_exp_a = 1'b1;
         if (w < 4)  begin exp_b[w] = w32; known_b[w] = 1'b1; end else ovf_exp_b = 1'b1;
      end
   endtask

   task automatic check_mem(input string tag);
      for (int a = 0; a < 64; a++) if (known_a[a]) begin
         instr_addr = a; #1;
         chk({tag, "_mem_a"}, data_a, exp_a[a]);
      end
      for (int a = 0; a < 4; a++) if (known_b[a]) begin
         instr_addr = a; #1;
         chk({tag, "_mem_b"}, data_b, exp_b[a]);
      end
      instr_addr = 32'd64;        #1; chk({tag, "_nop_a"},    data_a, 32'h0000_0013);
      instr_addr = 32'h8000_0001; #1; chk({tag, "_nop_a_hi"}, data_a, 32'h0000_0013);
      instr_addr = 32'd4;         #1; chk({tag, "_nop_b"},    data_b, 32'h0000_0013);
      chk({tag, "_ovf_a"}, ovf_a, ovf_exp_a);
      chk({tag, "_ovf_b"}, ovf_b, ovf_exp_b);
   endtask

   task automatic make_frame(input int n, output logic [7:0] q[$]);
      q = {};
      q.push_back(n[7:0]);
      q.push_back(n[15:8]);
      for (int i = 0; i < 4*n; i++) q.push_back(8'($urandom));
   endtask

   // Issues load_start (with a junk byte offered in the same cycle), then streams bytes until
   // stop_after have been accepted. A full frame also checks the done/release handshake.
   task automatic do_load(input logic [7:0] b[$], input bit gaps, input int stop_after,
                          output int nacc);
      int   i, cyc, bad_rst, dones, w;
      logic rdy;
      i = 0; cyc = 0; bad_rst = 0; dones = 0;
      @(negedge clk);
      chk("rdy_in_run", rdy_a, 1'b0);
      load_start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
      @(negedge clk);
      load_start = 1'b0; in_valid = 1'b0;
      chk("crst_after_start", crst_a, 1'b1);
      chk("loading_after_start", ld_a, 1'b1);
      while (i < stop_after && cyc < 2000) begin
         rdy = rdy_a;
         if (crst_a !== 1'b1 || crst_b !== 1'b1) bad_rst++;
         if (done_a !== 1'b0 || done_b !== 1'b0) dones++;
         in_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         load_start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data    = in_valid ? b[i] : 8'($urandom);
         if (in_valid && i >= 2 && ((i - 2) % 4) == 3) begin
            w = (i - 2) / 4;
            if (w < 64 && known_a[w]) begin
               instr_addr = w; #1;
               chk("old_data_on_write", data_a, exp_a[w]);
            end
         end
         @(negedge clk);
         if (in_valid && rdy) i++;
         cyc++;
      end
      in_valid = 1'b0; load_start = 1'b0;
      nacc = i;
      chk("frame_timeout", (cyc < 2000), 1'b1);
      chk("crst_during_frame", bad_rst, 0);
      chk("done_during_frame", dones, 0);
      if (stop_after == b.size()) begin
         chk("done_pulse_a", done_a, 1'b1);
         chk("done_pulse_b", done_b, 1'b1);
         chk("crst_released", crst_a, 1'b0);
         chk("loading_end", ld_a, 1'b0);
         @(negedge clk);
         chk("done_single", done_a, 1'b0);
         chk("crst_stays_low", crst_a, 1'b0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t        vt [8];
      logic [7:0]  f1 [$];
      logic [7:0]  fr [$];
      int          nacc;

      rst = 1'b1; in_valid = 1'b0; load_start = 1'b0; in_data = 8'h00; instr_addr = 32'd0;
      for (int a = 0; a < 64; a++) known_a[a] = 1'b0;
      for (int a = 0; a < 4; a++)  known_b[a] = 1'b0;
      ovf_exp_a = 1'b0; ovf_exp_b = 1'b0;

      //           rst   ls    vld   crst  rdy   ld
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         rst = vt[k].rst; load_start = vt[k].ls; in_valid = vt[k].vld; in_data = 8'h5A;
         @(negedge clk);
         chk($sformatf("vec%0d_crst", k),    crst_a, vt[k].e_crst);
         chk($sformatf("vec%0d_rdy", k),     rdy_a,  vt[k].e_rdy);
         chk($sformatf("vec%0d_loading", k), ld_a,   vt[k].e_ld);
         chk($sformatf("vec%0d_done", k),    done_a, 1'b0);
         chk($sformatf("vec%0d_ovf", k),     ovf_a,  1'b0);
      end
      rst = 1'b0; load_start = 1'b0; in_valid = 1'b0;

      f1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
      do_load(f1, 1'b0, f1.size(), nacc);
      model_frame(f1, nacc);
      instr_addr = 32'd1; #1;
      chk("f1_addr1", data_a, 32'h0020_0113);
      instr_addr = 32'd0; #1;
      chk("f1_addr0", data_a, 32'h0010_0093);
      check_mem("f1");

      // Bytes offered while idle must never be taken.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'($urandom);
         #1 chk("idle_rdy", rdy_a, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("idle_loading", ld_a, 1'b0);
      check_mem("idle");

      make_frame(3, fr);
      do_load(fr, 1'b1, fr.size(), nacc);
      model_frame(fr, nacc);
      check_mem("rnd3");
      do_load(f1, 1'b1, f1.size(), nacc);
      model_frame(f1, nacc);
      check_mem("f1_gaps");

      fr = '{8'h00, 8'h00};
      do_load(fr, 1'b0, 2, nacc);
      model_frame(fr, nacc);
      check_mem("n0");

      make_frame(5, fr);
      do_load(fr, 1'b0, fr.size(), nacc);
      model_frame(fr, nacc);
      check_mem("ovf5");
      repeat (3) @(negedge clk);
      chk("ovf_sticky", ovf_b, 1'b1);

      make_frame(2, fr);
      do_load(fr, 1'b0, 8, nacc);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_crst", crst_a, 1'b1);
      chk("midrst_loading", ld_a, 1'b0);
      chk("midrst_rdy", rdy_a, 1'b0);
      chk("midrst_done", done_a, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_release", crst_a, 1'b0);
      chk("midrst_no_done", done_a, 1'b0);
      model_frame(fr, nacc);
      check_mem("midrst");

      make_frame(4, fr);
      do_load(fr, 1'b1, fr.size(), nacc);
      model_frame(fr, nacc);
      check_mem("after_rst");

      for (int r = 0; r < 3; r++) begin
         make_frame($urandom_range(1, 70), fr);
         do_load(fr, 1'b1, fr.size(), nacc);
         model_frame(fr, nacc);
         check_mem($sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
